// File: rtl/pm_delay_pipe.sv
// Valid/ready delay pipe for program-memory words: STAGES registers, each fed by a
// LEVELS-deep transparent AND chain. Optional parity tracking via PM_DELAY_PARITY_EN.
module pm_delay_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 3,
  parameter int LEVELS = 20,
  parameter int OCC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [OCC_W-1:0]  occupancy
`ifdef PM_DELAY_PARITY_EN
  ,
  output logic              parity_err,
  input  logic              inj_err
`endif
);

`ifdef PM_DELAY_PARITY_EN
  localparam int SW = DATA_W + 1;
`else
  localparam int SW = DATA_W;
`endif

  logic [SW-1:0]    r_stage [STAGES];
  logic [STAGES-1:0] r_valid;
  logic [OCC_W-1:0] r_occ;
  logic [SW-1:0]    w_stage_d [STAGES];
  logic [SW-1:0]    w_entry_word;
  logic [STAGES:0]  w_vchain;
  logic             w_adv;
  logic             w_entry;
  logic             w_exit;

`ifdef PM_DELAY_PARITY_EN
  // Stored parity bit is even parity of the word, optionally corrupted for test.
  assign w_entry_word = {(^in_data) ^ inj_err, in_data};
`else
  assign w_entry_word = in_data;
`endif

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_stage[STAGES-1][DATA_W-1:0];
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;
  assign w_entry   = w_adv & in_valid;
  assign w_exit    = out_valid & out_ready;
  assign occupancy = r_occ;
  assign w_vchain  = {r_valid, in_valid};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    (* keep = "true", noprune *) logic [SW-1:0] w_chain [LEVELS+1];
    if (k == 0) begin : g_first
      assign w_chain[0] = w_entry_word;
    end else begin : g_next
      assign w_chain[0] = r_stage[k-1];
    end
    // Each level is x & x: logically transparent, but kept as real gate depth.
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
      assign w_chain[l+1] = w_chain[l] & w_chain[l];
    end
    assign w_stage_d[k] = w_chain[LEVELS];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_occ   <= '0;
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
        r_occ   <= '0;
      end else begin
        if (w_adv) r_valid <= w_vchain[STAGES-1:0];
        r_occ <= r_occ + OCC_W'(w_entry) - OCC_W'(w_exit);
      end
      // Data holds on flush so the dropped word never reaches out_data.
      if (w_adv && !flush) begin
        for (int k = 0; k < STAGES; k++) r_stage[k] <= w_stage_d[k];
      end
    end
  end

`ifdef PM_DELAY_PARITY_EN
  logic r_parity_err;
  logic w_last_bad;

  assign w_last_bad = w_vchain[STAGES-1] &
                      ((^w_stage_d[STAGES-1][DATA_W-1:0]) != w_stage_d[STAGES-1][DATA_W]);
  assign parity_err = r_parity_err;

  // Flag is aligned with the bad word while it sits at the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_parity_err <= 1'b0;
    else if (flush) r_parity_err <= 1'b0;
    else if (w_adv) r_parity_err <= w_last_bad;
  end
`endif

endmodule

// File: tb/tb_pm_delay_pipe.sv
// Directed self-checking bench for pm_delay_pipe (DATA_W=8, STAGES=3, LEVELS=20).
// Parity scenario runs only when PM_DELAY_PARITY_EN is defined.
module tb_pm_delay_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       flush;
  logic [4:0] occupancy;
`ifdef PM_DELAY_PARITY_EN
  logic       parity_err;
  logic       inj_err;
`endif

  int vectors;
  int miscompares;

  pm_delay_pipe #(.DATA_W(8), .STAGES(3), .LEVELS(20), .OCC_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PM_DELAY_PARITY_EN
    ,
    .parity_err(parity_err),
    .inj_err   (inj_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got ov=%b od=%h occ=%0d, want ov=0 od=00 occ=0",
               out_valid, out_data, occupancy);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    step();
  endtask

  task automatic test_stream();
    logic [7:0] din [7];
    logic       vin [7];
    logic       eov [7];
    logic [7:0] eod [7];
    logic [4:0] eocc [7];
    logic [4:0] peak;
    din  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
    vin  = '{1, 1, 1, 1, 0, 0, 0};
    eov  = '{0, 0, 1, 1, 1, 1, 0};
    eod  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    eocc = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
    peak = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = vin[i];
      in_data  = din[i];
      step();
      if (occupancy > peak) peak = occupancy;
      vectors++;
      if (out_valid !== eov[i] || occupancy !== eocc[i] || (eov[i] && out_data !== eod[i])) begin
        miscompares++;
        $display("[TB] FAIL stream[%0d]: got ov=%b od=%h occ=%0d, want ov=%b od=%h occ=%0d",
                 i, out_valid, out_data, occupancy, eov[i], eod[i], eocc[i]);
      end
    end
    vectors++;
    if (peak !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL stream_peak: got %0d, want 3", peak);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] fill [3];
    logic [7:0] eod  [3];
    logic [4:0] eocc [3];
    fill = '{8'hA5, 8'h5A, 8'hFF};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = fill[i];
      step();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || in_ready !== 1'b0 || occupancy !== 5'd3) begin
        miscompares++;
        $display("[TB] FAIL stall[%0d]: got ov=%b od=%h rdy=%b occ=%0d, want ov=1 od=a5 rdy=0 occ=3",
                 i, out_valid, out_data, in_ready, occupancy);
      end
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_data !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL release_ready: got rdy=%b od=%h, want rdy=1 od=a5", in_ready, out_data);
    end
    eod  = '{8'h5A, 8'hFF, 8'h00};
    eocc = '{5'd2, 5'd1, 5'd0};
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out_valid !== (i < 2) || occupancy !== eocc[i] || (i < 2 && out_data !== eod[i])) begin
        miscompares++;
        $display("[TB] FAIL drain[%0d]: got ov=%b od=%h occ=%0d, want ov=%b od=%h occ=%0d",
                 i, out_valid, out_data, occupancy, (i < 2), eod[i], eocc[i]);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] din [8];
    logic       vin [8];
    logic       eov [8];
    logic [7:0] eod [8];
    logic [4:0] eocc [8];
    din  = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    vin  = '{1, 0, 1, 0, 1, 0, 0, 0};
    eov  = '{0, 0, 1, 0, 1, 0, 1, 0};
    eod  = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    eocc = '{5'd1, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd1, 5'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = vin[i];
      in_data  = din[i];
      step();
      vectors++;
      if (out_valid !== eov[i] || occupancy !== eocc[i] || (eov[i] && out_data !== eod[i])) begin
        miscompares++;
        $display("[TB] FAIL bubble[%0d]: got ov=%b od=%h occ=%0d, want ov=%b od=%h occ=%0d",
                 i, out_valid, out_data, occupancy, eov[i], eod[i], eocc[i]);
      end
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61 + 8'(i);
      step();
    end
    vectors++;
    if (occupancy !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL flush_prefill: got occ=%0d, want 3", occupancy);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL flush_clear: got ov=%b occ=%0d, want ov=0 occ=0", out_valid, occupancy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || occupancy !== 5'd0 || out_data === 8'h77) begin
        miscompares++;
        $display("[TB] FAIL flush_after[%0d]: got ov=%b od=%h occ=%0d, want ov=0 occ=0 od!=77",
                 i, out_valid, out_data, occupancy);
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h81 + 8'(i);
      step();
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h81 || occupancy !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL prereset: got ov=%b od=%h occ=%0d, want ov=1 od=81 occ=3",
               out_valid, out_data, occupancy);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got ov=%b od=%h occ=%0d, want ov=0 od=00 occ=0",
               out_valid, out_data, occupancy);
    end
    step();
    #2 reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h91;
    step();
    in_data  = 8'h92;
    step();
    in_valid = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h91 || occupancy !== 5'd2) begin
      miscompares++;
      $display("[TB] FAIL restart: got ov=%b od=%h occ=%0d, want ov=1 od=91 occ=2",
               out_valid, out_data, occupancy);
    end
    step();
    step();
  endtask

`ifdef PM_DELAY_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h03;
    inj_err   = 1'b1;
    step();
    in_data   = 8'h07;
    inj_err   = 1'b0;
    step();
    in_valid  = 1'b0;
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h03 || parity_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity_bad: got ov=%b od=%h perr=%b, want ov=1 od=03 perr=1",
               out_valid, out_data, parity_err);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h07 || parity_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL parity_good: got ov=%b od=%h perr=%b, want ov=1 od=07 perr=0",
               out_valid, out_data, parity_err);
    end
    step();
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b1;
    flush       = 1'b0;
`ifdef PM_DELAY_PARITY_EN
    inj_err     = 1'b0;
`endif
    #2;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_flush();
    test_async_reset();
`ifdef PM_DELAY_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no completion, want finish before 20000");
    $fatal(1, "[TB] timeout");
  end

endmodule
